// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides.
// Optional signed saturation of the result is enabled by defining CLA_SAT_EN.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             sat
);

    localparam int unsigned GROUPS = WIDTH / 4;

    // Carry into group k, flattened as a sum of products over all lower groups.
    function automatic logic group_carry(input logic [GROUPS-1:0] gg,
                                         input logic [GROUPS-1:0] gp,
                                         input logic              c_in,
                                         input int unsigned       k);
        logic c;
        logic prod;
        c = 1'b0;
        for (int unsigned j = 0; j < k; j++) begin
            prod = gg[j];
            for (int unsigned i = j + 1; i < k; i++) begin
                prod = prod & gp[i];
            end
            c = c | prod;
        end
        prod = c_in;
        for (int unsigned i = 0; i < k; i++) begin
            prod = prod & gp[i];
        end
        return c | prod;
    endfunction

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_en;
    logic              s2_en;

    logic [WIDTH-1:0]  beff;
    logic [WIDTH-1:0]  p_c;
    logic [WIDTH-1:0]  g_c;
    logic [GROUPS-1:0] gg_c;
    logic [GROUPS-1:0] gp_c;
    logic              c0_c;

    logic [WIDTH-1:0]  s1_p;
    logic [WIDTH-1:0]  s1_g;
    logic [GROUPS-1:0] s1_gg;
    logic [GROUPS-1:0] s1_gp;
    logic              s1_c0;

    logic [GROUPS:0]   grp_c;
    logic [WIDTH:0]    bit_c;
    logic [WIDTH-1:0]  sum_raw;
    logic              cout_raw;
    logic              ovf_raw;
    logic [WIDTH-1:0]  sum_nxt;

    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Stage 1: operand conditioning, bit propagate/generate and group lookahead terms.
    always_comb begin
        beff = sub ? ~b : b;
        c0_c = sub ? 1'b1 : cin;
        p_c  = a ^ beff;
        g_c  = a & beff;
        gg_c = '0;
        gp_c = '0;
        for (int unsigned k = 0; k < GROUPS; k++) begin
            gg_c[k] = g_c[4*k+3]
                    | (p_c[4*k+3] & g_c[4*k+2])
                    | (p_c[4*k+3] & p_c[4*k+2] & g_c[4*k+1])
                    | (p_c[4*k+3] & p_c[4*k+2] & p_c[4*k+1] & g_c[4*k]);
            gp_c[k] = &p_c[4*k +: 4];
        end
    end

    // Stage 2: group carries, in-group carries and the final sum.
    always_comb begin
        grp_c = '0;
        bit_c = '0;
        for (int unsigned k = 0; k <= GROUPS; k++) begin
            grp_c[k] = group_carry(s1_gg, s1_gp, s1_c0, k);
        end
        for (int unsigned k = 0; k < GROUPS; k++) begin
            bit_c[4*k]   = grp_c[k];
            bit_c[4*k+1] = s1_g[4*k] | (s1_p[4*k] & grp_c[k]);
            bit_c[4*k+2] = s1_g[4*k+1]
                         | (s1_p[4*k+1] & s1_g[4*k])
                         | (s1_p[4*k+1] & s1_p[4*k] & grp_c[k]);
            bit_c[4*k+3] = s1_g[4*k+2]
                         | (s1_p[4*k+2] & s1_g[4*k+1])
                         | (s1_p[4*k+2] & s1_p[4*k+1] & s1_g[4*k])
                         | (s1_p[4*k+2] & s1_p[4*k+1] & s1_p[4*k] & grp_c[k]);
        end
        bit_c[WIDTH] = grp_c[GROUPS];
    end

    assign sum_raw  = s1_p ^ bit_c[WIDTH-1:0];
    assign cout_raw = bit_c[WIDTH];
    assign ovf_raw  = bit_c[WIDTH-1] ^ bit_c[WIDTH];

`ifdef CLA_SAT_EN
    logic s1_a_msb;
    logic sat_q;

    // On signed overflow both operands share a sign; clamp toward that sign's extreme.
    assign sum_nxt = ovf_raw ? {s1_a_msb, {(WIDTH-1){~s1_a_msb}}} : sum_raw;
    assign sat     = sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_msb <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            if (s1_en) s1_a_msb <= a[WIDTH-1];
            if (s2_en) sat_q    <= ovf_raw;
        end
    end
`else
    assign sum_nxt = sum_raw;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_c0    <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_p     <= p_c;
            s1_g     <= g_c;
            s1_gg    <= gg_c;
            s1_gp    <= gp_c;
            s1_c0    <= c0_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            sum_q    <= sum_nxt;
            cout_q   <= cout_raw;
            ovf_q    <= ovf_raw;
        end
    end

    assign out_valid = s2_valid;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
